bf16_mul_arbiter: RTL and testbench
===================================

BF16_MUL_ARBITER -- requirements
Module: bf16_mul_arbiter

Interface
REQ-001 SHALL have parameter PTR_INIT, default 0: round-robin pointer value after reset (0 or 1).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  requester n offers an operand pair.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1  requester n handshake accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  16  bfloat16 operands (sign, 8-bit exponent, 7-bit fraction).
REQ-007 SHALL have port res_valid  output  1  result held and valid.
REQ-008 SHALL have port res_ready  input  1  consumer accepts the result.
REQ-009 SHALL have port res_data  output  16  bfloat16 product.
REQ-010 SHALL have port res_id  output  1  index of the requester that owns res_data.
REQ-011 SHALL have port op_cnt  output  16  count of completed result handshakes.

Function
REQ-012 SHALL instantiate exactly one team bf16 multiplier (module mul) and share it between both requesters; res_data is its 16-bit sum output for the latched operands.
REQ-013 SHALL implement three states: IDLE, CALC, DONE.
REQ-014 IDLE: SHALL assert reqN_ready combinationally for the granted requester only; ready for the non-granted requester is 0; both readys are 0 outside IDLE.
REQ-015 Grant: only one valid -> that one; both valid -> requester != ptr... precisely, the requester whose index differs from last-granted pointer; none valid -> no ready.
REQ-016 On IDLE handshake (reqN_valid & reqN_ready): SHALL latch a, b, id = N into operand registers, set pointer = N, go to CALC.
REQ-017 CALC: exactly one cycle; SHALL register mul output into res_data, keep res_id, set res_valid = 1, go to DONE.
REQ-018 DONE: res_valid = 1, res_data and res_id held stable until res_ready = 1; on res_ready SHALL clear res_valid, increment op_cnt, go to IDLE.
REQ-019 Latency: handshake at edge k -> res_valid high after edge k+2; minimum issue interval 3 cycles (new request accepted no earlier than the cycle after result handshake).
REQ-020 op_cnt SHALL wrap 0xFFFF -> 0x0000 without flag.
REQ-021 Requester valid dropping in IDLE without handshake SHALL leave pointer unchanged; operand changes while not accepted SHALL have no effect.
REQ-022 res_ready asserted in IDLE or CALC SHALL be ignored.
REQ-023 Pointer SHALL change only on a request handshake.

Reset
REQ-024 rst = 1 SHALL immediately (asynchronously) force state = IDLE, pointer = PTR_INIT, res_valid = 0, res_data = 0x0000, res_id = 0, op_cnt = 0, operand registers = 0.
REQ-025 rst asserted during CALC or DONE SHALL abort the operation; the pending result is discarded and op_cnt not incremented.
REQ-026 First grant after reset with both valid SHALL go to requester 1 - PTR_INIT.

Verification
REQ-027 Single request: req0 a=0x3F80 (1.0), b=0x4000 (2.0), res_ready=1 -> req0_ready=1 in IDLE, res_valid 2 cycles later, res_data=0x4000, res_id=0, op_cnt=1.
REQ-028 Contention: both valid continuously, PTR_INIT=0, res_ready=1, req1 a=0x4040 (3.0), b=0x4000 (2.0) -> grants alternate 1,0,1,0; req1 results 0x40C0 (6.0) with res_id=1.
REQ-029 Backpressure: res_ready=0 for 5 cycles after res_valid -> res_data/res_id stable, both readys 0, op_cnt unchanged; res_ready=1 -> op_cnt+1, IDLE next cycle.
REQ-030 Reset mid-op: rst pulsed in CALC -> res_valid=0, op_cnt=0, state IDLE, pointer=PTR_INIT immediately, without clock edge.
REQ-031 Sign/wrap: a=0xBF80 (-1.0), b=0x3F80 (1.0) -> res_data=0xBF80; preload 65535 completions -> next completion op_cnt=0x0000.

Source files
------------

// File: rtl/bf16_mul_arbiter.sv
// bf16_mul_arbiter: round-robin arbiter sharing one bf16 multiplier between two requesters
module mul (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);
    logic              s, za, zb, ia, ib, na, nb, g, st;
    logic [7:0]        ea, eb, rf;
    logic [15:0]       p;
    logic [6:0]        fr;
    logic signed [9:0] e;
    assign s  = a[15] ^ b[15];
    assign ea = a[14:7];
    assign eb = b[14:7];
    assign za = ea == 8'd0;
    assign zb = eb == 8'd0;
    assign ia = ea == 8'hFF;
    assign ib = eb == 8'hFF;
    assign na = ia & |a[6:0];
    assign nb = ib & |b[6:0];
    assign p  = {8'd0, 1'b1, a[6:0]} * {8'd0, 1'b1, b[6:0]};
    assign fr = p[15] ? p[14:8] : p[13:7];
    assign g  = p[15] ? p[7] : p[6];
    assign st = p[15] ? |p[6:0] : |p[5:0];
    assign rf = {1'b0, fr} + {7'd0, g & (st | fr[0])};
    assign e  = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127
              + $signed({9'd0, p[15]}) + $signed({9'd0, rf[7]});
    // NaN, infinity, flush-to-zero and overflow handling around the rounded product
    always_comb begin
        sum = (na | nb | (ia & zb) | (ib & za)) ? 16'h7FC0 :
              (ia | ib)                         ? {s, 8'hFF, 7'd0} :
              (za | zb | (e <= 10'sd0))         ? {s, 15'd0} :
              (e >= 10'sd255)                   ? {s, 8'hFF, 7'd0} :
                                                  {s, e[7:0], rf[6:0]};
    end
endmodule

module bf16_mul_arbiter #(
    parameter logic PTR_INIT = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [15:0] req0_a,
    input  logic [15:0] req0_b,
    input  logic [15:0] req1_a,
    input  logic [15:0] req1_b,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        res_id,
    output logic [15:0] op_cnt
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      state, state_nx;
    logic        ptr, op_id, g0, g1, hs;
    logic [15:0] op_a, op_b, prod;
    mul u_mul (.a(op_a), .b(op_b), .sum(prod));
    assign g1 = req1_valid & (~req0_valid | ~ptr);
    assign g0 = req0_valid & ~g1;
    assign hs = (state == IDLE) & (g0 | g1);
    // grant readys and next state
    always_comb begin
        req0_ready = (state == IDLE) & g0;
        req1_ready = (state == IDLE) & g1;
        state_nx   = (state == IDLE) ? (hs ? CALC : IDLE) :
                     (state == CALC) ? DONE :
                     (res_ready ? IDLE : DONE);
    end
    // state, operand latch, result register and completion counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= PTR_INIT;
            op_a      <= 16'd0;
            op_b      <= 16'd0;
            op_id     <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= 16'd0;
            res_id    <= 1'b0;
            op_cnt    <= 16'd0;
        end else begin
            state <= state_nx;
            if (hs) begin
                op_a  <= g1 ? req1_a : req0_a;
                op_b  <= g1 ? req1_b : req0_b;
                op_id <= g1;
                ptr   <= g1;
            end
            if (state == CALC) begin
                res_data  <= prod;
                res_id    <= op_id;
                res_valid <= 1'b1;
            end
            if (state == DONE && res_ready) begin
                res_valid <= 1'b0;
                op_cnt    <= op_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_bf16_mul_arbiter.sv
// tb_bf16_mul_arbiter: directed self-checking bench for bf16_mul_arbiter
module tb_bf16_mul_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic        res_valid, res_ready, res_id;
    logic [15:0] req0_a, req0_b, req1_a, req1_b, res_data, op_cnt;
    int          vectors = 0;
    int          miscompares = 0;
    logic        eid;

    bf16_mul_arbiter #(.PTR_INIT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        req0_a = 16'd0; req0_b = 16'd0; req1_a = 16'd0; req1_b = 16'd0;
        #1 rst = 1'b1;
        #1;
        chk1("rst_valid", res_valid, 1'b0);
        chk("rst_data", res_data, 16'h0000);
        chk1("rst_id", res_id, 1'b0);
        chk("rst_cnt", op_cnt, 16'h0000);
        chk1("rst_rdy0", req0_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        req0_valid = 1'b1; req0_a = 16'h3F80; req0_b = 16'h4000; res_ready = 1'b1;
        #1;
        chk1("t1_rdy0", req0_ready, 1'b1);
        chk1("t1_rdy1", req1_ready, 1'b0);
        @(negedge clk);
        chk1("t1_calc_rdy0", req0_ready, 1'b0);
        chk1("t1_calc_valid", res_valid, 1'b0);
        req0_valid = 1'b0;
        @(negedge clk);
        chk1("t1_valid", res_valid, 1'b1);
        chk("t1_data", res_data, 16'h4000);
        chk1("t1_id", res_id, 1'b0);
        chk("t1_cnt_before", op_cnt, 16'd0);
        @(negedge clk);
        chk1("t1_valid_clr", res_valid, 1'b0);
        chk("t1_cnt", op_cnt, 16'd1);

        req0_valid = 1'b1; req1_valid = 1'b1; req1_a = 16'h4040; req1_b = 16'h4000;
        for (int i = 0; i < 4; i++) begin
            eid = (i % 2 == 0);
            #1;
            chk1("arb_rdy1", req1_ready, eid);
            chk1("arb_rdy0", req0_ready, !eid);
            @(negedge clk);
            @(negedge clk);
            chk1("arb_valid", res_valid, 1'b1);
            chk1("arb_id", res_id, eid);
            chk("arb_data", res_data, eid ? 16'h40C0 : 16'h4000);
            @(negedge clk);
        end
        chk("arb_cnt", op_cnt, 16'd5);

        req1_valid = 1'b0; req0_a = 16'hBF80; req0_b = 16'h3F80; res_ready = 1'b0;
        #1;
        chk1("bp_rdy0_idle", req0_ready, 1'b1);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        chk1("bp_valid0", res_valid, 1'b1);
        chk("sign_data", res_data, 16'hBF80);
        chk1("bp_id0", res_id, 1'b0);
        req1_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk1("bp_valid", res_valid, 1'b1);
            chk("bp_data", res_data, 16'hBF80);
            chk1("bp_id", res_id, 1'b0);
            chk1("bp_rdy0", req0_ready, 1'b0);
            chk1("bp_rdy1", req1_ready, 1'b0);
            chk("bp_cnt", op_cnt, 16'd5);
        end
        res_ready = 1'b1;
        @(negedge clk);
        chk1("bp_valid_clr", res_valid, 1'b0);
        chk("bp_cnt_inc", op_cnt, 16'd6);
        req0_valid = 1'b1;
        #1;
        chk1("ptr_rdy1", req1_ready, 1'b1);
        chk1("ptr_rdy0", req0_ready, 1'b0);
        @(negedge clk);
        chk1("calc_rdy1", req1_ready, 1'b0);
        #1 rst = 1'b1;
        #1;
        chk1("mid_rst_valid", res_valid, 1'b0);
        chk("mid_rst_cnt", op_cnt, 16'h0000);
        chk("mid_rst_data", res_data, 16'h0000);
        chk1("mid_rst_rdy1", req1_ready, 1'b1);
        chk1("mid_rst_rdy0", req0_ready, 1'b0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        chk1("post_rst_valid", res_valid, 1'b0);

        force dut.op_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.op_cnt;
        #1;
        chk("wrap_pre", op_cnt, 16'hFFFF);
        req0_valid = 1'b1; req0_a = 16'h3FC0; req0_b = 16'h3FC0; res_ready = 1'b1;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        chk("norm_data", res_data, 16'h4010);
        chk("wrap_hold", op_cnt, 16'hFFFF);
        @(negedge clk);
        chk("wrap_cnt", op_cnt, 16'h0000);
        chk1("wrap_valid_clr", res_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
